// File: rtl/unidade_exibicao.sv
// Shows a stored LED sequence one item at a time: each item is lit for
// TEMPO_ON cycles, then dark for TEMPO_OFF cycles, up to address limite.
module unidade_exibicao #(
  parameter int TEMPO_ON  = 1000,
  parameter int TEMPO_OFF = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] dado,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h3,
    ACENDE     = 4'h5,
    APAGA      = 4'h6,
    PROXIMO    = 4'h7,
    FIM        = 4'hD
  } estado_t;

  localparam logic [31:0] ON_LAST  = 32'(TEMPO_ON - 1);
  localparam logic [31:0] OFF_LAST = 32'(TEMPO_OFF - 1);

  estado_t     estado;
  logic [31:0] timer;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= INICIAL;
      endereco <= 4'h0;
      timer    <= 32'd0;
    end else begin
      case (estado)
        INICIAL: if (iniciar) estado <= PREPARACAO;
        PREPARACAO: begin
          endereco <= 4'h0;
          timer    <= 32'd0;
          estado   <= ACENDE;
        end
        ACENDE: begin
          if (timer == ON_LAST) begin
            timer  <= 32'd0;
            estado <= APAGA;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        APAGA: begin
          // limite is compared live here, so a change mid-display applies at this point
          if (timer == OFF_LAST) begin
            timer  <= 32'd0;
            estado <= (endereco == limite) ? FIM : PROXIMO;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        PROXIMO: begin
          endereco <= endereco + 4'h1;
          estado   <= ACENDE;
        end
        FIM: if (iniciar) estado <= PREPARACAO;
        default: begin
          timer  <= 32'd0;
          estado <= INICIAL;
        end
      endcase
    end
  end

  // Outputs are pure decodes of the state register; leds passes the memory
  // read straight through so the lit item tracks endereco with no lag.
  always_comb begin
    leds      = 4'h0;
    exibindo  = 1'b0;
    pronto    = 1'b0;
    db_estado = 4'hF;
    case (estado)
      INICIAL:    db_estado = 4'h0;
      PREPARACAO: begin db_estado = 4'h3; exibindo = 1'b1; end
      ACENDE:     begin db_estado = 4'h5; exibindo = 1'b1; leds = dado; end
      APAGA:      begin db_estado = 4'h6; exibindo = 1'b1; end
      PROXIMO:    begin db_estado = 4'h7; exibindo = 1'b1; end
      FIM:        begin db_estado = 4'hD; pronto = 1'b1; end
      default:    db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_unidade_exibicao.sv
// Bench for unidade_exibicao: per-cycle comparison against a trace built
// from the display rules (items lit, dark gaps, step cycles, final state).
module tb_unidade_exibicao;
  localparam int ON  = 4;
  localparam int OFF = 2;

  logic       clock = 1'b0;
  logic       reset, iniciar;
  logic [3:0] limite, dado, endereco, leds, db_estado;
  logic       exibindo, pronto;
  logic [3:0] mem [16];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] leds;
    logic [3:0] endereco;
    logic       exibindo;
    logic       pronto;
    logic [3:0] estado;
  } obs_t;

  obs_t       exp_q[$];
  logic [3:0] last_end;

  unidade_exibicao #(.TEMPO_ON(ON), .TEMPO_OFF(OFF)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .limite(limite),
    .dado(dado), .endereco(endereco), .leds(leds), .exibindo(exibindo),
    .pronto(pronto), .db_estado(db_estado)
  );

  assign dado = mem[endereco];

  // clock / reset
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input obs_t e);
    check({tag, ".leds"},      32'(leds),      32'(e.leds));
    check({tag, ".endereco"},  32'(endereco),  32'(e.endereco));
    check({tag, ".exibindo"},  32'(exibindo),  32'(e.exibindo));
    check({tag, ".pronto"},    32'(pronto),    32'(e.pronto));
    check({tag, ".db_estado"}, 32'(db_estado), 32'(e.estado));
  endtask

  // Reference trace: one entry per clock after iniciar is sampled.
  task automatic build(input logic [3:0] lim, input bit hold);
    exp_q.delete();
    exp_q.push_back('{4'h0, last_end, 1'b1, 1'b0, 4'h3});
    for (int i = 0; i <= int'(lim); i++) begin
      for (int c = 0; c < ON; c++)  exp_q.push_back('{mem[i], 4'(i), 1'b1, 1'b0, 4'h5});
      for (int c = 0; c < OFF; c++) exp_q.push_back('{4'h0, 4'(i), 1'b1, 1'b0, 4'h6});
      if (i != int'(lim)) exp_q.push_back('{4'h0, 4'(i), 1'b1, 1'b0, 4'h7});
    end
    exp_q.push_back('{4'h0, lim, 1'b0, 1'b1, 4'hD});
    if (hold) exp_q.push_back('{4'h0, lim, 1'b1, 1'b0, 4'h3});
    last_end = lim;
  endtask

  // driver: one display run; limite may be switched to lim_new after chg_at cycles
  task automatic run(input string name, input logic [3:0] lim, input bit hold,
                     input int chg_at, input logic [3:0] lim_new);
    obs_t       e;
    int         n = 0;
    int         t_acende = -1;
    int         t_fim = -1;
    logic [3:0] eff;
    eff = (chg_at >= 0) ? lim_new : lim;
    limite  = lim;
    iniciar = 1'b1;
    build(eff, hold);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step();
      n++;
      if (!hold) iniciar = 1'b0;
      if (n == chg_at) limite = lim_new;
      check_cycle($sformatf("%s.c%0d", name, n), e);
      if (db_estado == 4'h5 && t_acende < 0) t_acende = n;
      if (db_estado == 4'hD && t_fim < 0) t_fim = n;
    end
    check({name, ".duration"}, 32'(t_fim - t_acende),
          32'((int'(eff) + 1) * (ON + OFF) + int'(eff)));
    if (!hold) begin
      for (int i = 0; i < 3; i++) begin
        step();
        check_cycle($sformatf("%s.idle%0d", name, i), '{4'h0, eff, 1'b0, 1'b1, 4'hD});
      end
    end
    iniciar = 1'b0;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b0;
    step();
    check_cycle(name, '{4'h0, 4'h0, 1'b0, 1'b0, 4'h0});
    reset = 1'b1;
    last_end = 4'h0;
  endtask

  task automatic idle_check(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      limite = 4'($urandom_range(0, 15));
      step();
      check_cycle($sformatf("%s.%0d", name, i), '{4'h0, 4'h0, 1'b0, 1'b0, 4'h0});
    end
  endtask

  initial begin
    reset    = 1'b0;
    iniciar  = 1'b0;
    limite   = 4'h0;
    last_end = 4'h0;
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    step();
    do_reset("reset0");
    idle_check("idle_after_reset", 5);

    mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4;
    run("seq3", 4'd2, 1'b0, -1, 4'd0);

    mem[0] = 4'h8;
    run("single", 4'd0, 1'b0, -1, 4'd0);

    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
    run("lim_change", 4'd6, 1'b0, 2, 4'd1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
      run($sformatf("rand%0d", r), 4'($urandom_range(0, 7)), 1'b0, -1, 4'd0);
    end

    run("hold", 4'd1, 1'b1, -1, 4'd0);
    do_reset("reset_hold");
    idle_check("idle_hold", 3);

    // reset in the middle of the second lit item
    limite  = 4'd3;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("mid.db_estado", 32'(db_estado), 32'h5);
    check("mid.endereco", 32'(endereco), 32'h1);
    do_reset("reset_mid");
    idle_check("idle_mid", 4);

    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    run("full16", 4'd15, 1'b0, -1, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
